// File: rtl/instr_fetch_mt_pkg.sv
// Shared widths, error-flag bit positions and sizing helper for the multi-thread fetch unit.
package instr_fetch_mt_pkg;

  localparam int ERR_W          = 4;
  localparam int ERR_INV_RELOAD = 0;
  localparam int ERR_STK_OVF    = 1;
  localparam int ERR_STK_UNF    = 2;
  localparam int ERR_CF_NO_NT   = 3;

  // Bits needed to index n entries; never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instr_fetch_mt_thread_ret_stack.sv
// Per-thread call/return stack: LUTRAM storage plus one pointer per thread counting 0..DEPTH.
module thread_ret_stack
  import instr_fetch_mt_pkg::*;
#(
  parameter int N_THREADS = 6,
  parameter int DEPTH     = 2,
  parameter int DATA_W    = 10,
  localparam int TN_W     = idx_width(N_THREADS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [TN_W-1:0]   thread_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = idx_width(DEPTH);

  logic [SP_W-1:0]   sp_q [N_THREADS];
  logic [DATA_W-1:0] stk_mem [N_THREADS][DEPTH];
  logic [SP_W-1:0]   sp_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic [IDX_W-1:0]  push_idx_s;

  assign sp_s       = sp_q[thread_i];
  assign full_o     = (sp_s == SP_W'(DEPTH));
  assign empty_o    = (sp_s == SP_W'(0));
  assign top_idx_s  = IDX_W'(sp_s - SP_W'(1));
  assign push_idx_s = IDX_W'(sp_s);
  assign pop_data_o = stk_mem[thread_i][top_idx_s];

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) stk_mem[thread_i][push_idx_s] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < N_THREADS; t++) sp_q[t] <= SP_W'(0);
    end else if (push_i && !full_o) begin
      sp_q[thread_i] <= sp_s + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_q[thread_i] <= sp_s - SP_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_mt.sv
// Multi-thread instruction fetch: per-thread IP context, return stacks, entry table and
// a read-first program store feeding one instruction per cycle.
module instr_fetch_mt
  import instr_fetch_mt_pkg::*;
#(
  parameter int N_THREADS   = 6,
  parameter int IADDR_LEN   = 10,
  parameter int INSTR_LEN   = 16,
  parameter int N_ENTRY_PTS = 4,
  parameter int STACK_DEPTH = 2,
  localparam int TN_W       = idx_width(N_THREADS),
  localparam int EP_W       = idx_width(N_ENTRY_PTS)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [TN_W-1:0]      thread_num,
  input  logic [TN_W-1:0]      thread_num_ahead,
  input  logic [EP_W-1:0]      entry_pt_curr,
  input  logic                 INIT,
  input  logic                 NEXT_THREAD,
  input  logic                 RELOAD,
  input  logic                 INVALIDATE,
  input  logic                 INSTR_WAIT,
  input  logic                 EXECUTED,
  input  logic                 JUMP,
  input  logic                 CALL,
  input  logic                 RET,
  input  logic [IADDR_LEN-1:0] jump_addr,
  input  logic                 ep_wr_en,
  input  logic [EP_W-1:0]      ep_wr_idx,
  input  logic [IADDR_LEN-1:0] ep_wr_addr,
  input  logic                 prog_wr_en,
  input  logic [IADDR_LEN-1:0] prog_wr_addr,
  input  logic [INSTR_LEN-1:0] prog_wr_data,
  output logic [INSTR_LEN-1:0] instruction,
  output logic                 instr_valid,
  output logic [IADDR_LEN-1:0] ip_eff,
  output logic [ERR_W-1:0]     err
);

  logic [IADDR_LEN-1:0] ip_mem   [N_THREADS];
  logic [INSTR_LEN-1:0] prog_mem [2**IADDR_LEN];
  logic [IADDR_LEN-1:0] entry_q  [N_ENTRY_PTS];

  logic [IADDR_LEN-1:0] ip_eff_q, ip_eff_d, ip_curr_q, ip_curr_d;
  logic [IADDR_LEN-1:0] ip_wr_data_s, ip_inc_s, ip_ahead_s, pop_data_s;
  logic [INSTR_LEN-1:0] instr_q;
  logic                 instr_valid_q, instr_valid_d, fetch_en_q, fetch_en_d, rd_en_s;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 push_s, pop_s, stk_full_s, stk_empty_s, ovf_s, unf_s;

  assign ip_inc_s   = ip_eff_q + IADDR_LEN'(1);
  assign ip_ahead_s = ip_mem[thread_num_ahead];

  thread_ret_stack #(
    .N_THREADS (N_THREADS),
    .DEPTH     (STACK_DEPTH),
    .DATA_W    (IADDR_LEN)
  ) u_ret_stack (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .thread_i    (thread_num),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (ip_inc_s),
    .pop_data_o  (pop_data_s),
    .full_o      (stk_full_s),
    .empty_o     (stk_empty_s)
  );

  // Value saved into the current thread's IP slot; control flow counts only with NEXT_THREAD.
  always_comb begin
    ip_wr_data_s = ip_eff_q;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    ovf_s        = 1'b0;
    unf_s        = 1'b0;
    if (INIT) begin
      ip_wr_data_s = entry_q[entry_pt_curr];
    end else if (NEXT_THREAD && JUMP) begin
      ip_wr_data_s = jump_addr;
    end else if (NEXT_THREAD && CALL) begin
      ip_wr_data_s = jump_addr;
      push_s       = !stk_full_s;
      ovf_s        = stk_full_s;
    end else if (NEXT_THREAD && RET) begin
      if (stk_empty_s) begin
        ip_wr_data_s = ip_inc_s;
        unf_s        = 1'b1;
      end else begin
        ip_wr_data_s = pop_data_s;
        pop_s        = 1'b1;
      end
    end else if (EXECUTED) begin
      ip_wr_data_s = ip_inc_s;
    end else begin
      ip_wr_data_s = ip_eff_q;
    end
  end

  always_comb begin
    err_d                 = err_q;
    err_d[ERR_INV_RELOAD] = err_q[ERR_INV_RELOAD] | (RELOAD & INVALIDATE);
    err_d[ERR_STK_OVF]    = err_q[ERR_STK_OVF] | ovf_s;
    err_d[ERR_STK_UNF]    = err_q[ERR_STK_UNF] | unf_s;
    err_d[ERR_CF_NO_NT]   = err_q[ERR_CF_NO_NT] | ((JUMP | CALL | RET) & ~NEXT_THREAD);
  end

  // RELOAD dominates INVALIDATE; a read is issued only while fetching and not stalled.
  always_comb begin
    rd_en_s       = 1'b0;
    ip_curr_d     = ip_curr_q;
    instr_valid_d = instr_valid_q;
    fetch_en_d    = fetch_en_q;
    ip_eff_d      = ip_eff_q;
    if (RELOAD) begin
      ip_curr_d     = ip_ahead_s;
      instr_valid_d = 1'b0;
      fetch_en_d    = 1'b1;
    end else if (INVALIDATE) begin
      instr_valid_d = 1'b0;
      fetch_en_d    = 1'b0;
    end else if (fetch_en_q && !INSTR_WAIT) begin
      rd_en_s       = 1'b1;
      ip_curr_d     = ip_curr_q + IADDR_LEN'(1);
      instr_valid_d = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    if (RELOAD) begin
      ip_eff_d = ip_ahead_s;
    end else if (EXECUTED && !NEXT_THREAD) begin
      ip_eff_d = ip_inc_s;
    end else begin
      ip_eff_d = ip_eff_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ip_eff_q      <= IADDR_LEN'(0);
      ip_curr_q     <= IADDR_LEN'(0);
      instr_valid_q <= 1'b0;
      fetch_en_q    <= 1'b0;
      err_q         <= ERR_W'(0);
    end else begin
      ip_eff_q      <= ip_eff_d;
      ip_curr_q     <= ip_curr_d;
      instr_valid_q <= instr_valid_d;
      fetch_en_q    <= fetch_en_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int e = 0; e < N_ENTRY_PTS; e++) entry_q[e] <= IADDR_LEN'(0);
    end else if (ep_wr_en) begin
      entry_q[ep_wr_idx] <= ep_wr_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT || NEXT_THREAD) ip_mem[thread_num] <= ip_wr_data_s;
  end

  // Separate write and registered read processes give read-first behaviour on collisions.
  always_ff @(posedge CLK) begin
    if (prog_wr_en) prog_mem[prog_wr_addr] <= prog_wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_q <= INSTR_LEN'(0);
    end else if (rd_en_s) begin
      instr_q <= prog_mem[ip_curr_q];
    end
  end

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign ip_eff      = ip_eff_q;
  assign err         = err_q;

endmodule

// File: doc/instr_fetch_mt.md
Name: instr_fetch_mt

Overview:
Next-generation multi-thread instruction fetch unit for the sha256crypt CPU. It keeps one instruction pointer (IP) and one call/return stack per thread, and holds a runtime-loadable entry-point table. It fetches from an SDP block-RAM program store that is writable through a load port, and presents one instruction per cycle to the decode/execute pipeline. Thread selection stays in the external thread_number block; this unit consumes its current and look-ahead thread numbers.

Parameters:
N_THREADS, 6, hardware thread count; TN_W = MSB(N_THREADS-1)+1.
IADDR_LEN, 10, instruction address width.
INSTR_LEN, 16, instruction width.
N_ENTRY_PTS, 4, entry-point table size; EP_W = MSB(N_ENTRY_PTS-1)+1.
STACK_DEPTH, 2, return-stack entries per thread (power of 2, at least 1).

Ports:
CLK  in  1  clock, all logic on the rising edge.
RST_N  in  1  reset, asynchronous, active-low.
thread_num  in  TN_W  thread currently executing.
thread_num_ahead  in  TN_W  thread to load on RELOAD.
entry_pt_curr  in  EP_W  entry-point index used by INIT.
INIT  in  1  set IP[thread_num] from the entry-point table.
NEXT_THREAD  in  1  store the current thread's IP context.
RELOAD  in  1  load IP_curr and IP_eff from IP[thread_num_ahead].
INVALIDATE  in  1  drop prefetched instruction and stop fetching.
INSTR_WAIT  in  1  stall fetch; hold the output instruction.
EXECUTED  in  1  advance IP_eff by one.
JUMP  in  1  branch to jump_addr.
CALL  in  1  push the return address, branch to jump_addr.
RET  in  1  pop the return address and branch to it.
jump_addr  in  IADDR_LEN  branch/call target.
ep_wr_en, ep_wr_idx[EP_W], ep_wr_addr[IADDR_LEN]  in  entry-table write port.
prog_wr_en, prog_wr_addr[IADDR_LEN], prog_wr_data[INSTR_LEN]  in  program-store write port.
instruction  out  INSTR_LEN  fetched instruction.
instr_valid  out  1  instruction holds a valid fetch for IP_curr-1.
ip_eff  out  IADDR_LEN  effective IP of the running thread.
err  out  4  sticky error flags.

Behaviour:
- Reset (RST_N=0, async): instruction=0, instr_valid=0, IP_curr=0, ip_eff=0, err=0, all stack pointers=0, entry table all 0, fetch stopped.
- IP_mem and stack RAMs are not reset; INIT must be applied to a thread before its first RELOAD.
- IP_mem write happens on INIT|NEXT_THREAD, into IP[thread_num]. Priority:
  - INIT: entry[entry_pt_curr]
  - JUMP: jump_addr
  - CALL: jump_addr, and push ip_eff+1
  - RET: pop value
  - EXECUTED: ip_eff+1
  - otherwise: ip_eff
- JUMP/CALL/RET are legal only together with NEXT_THREAD. Without it, no IP or stack change and err[3]<=1.
- Mutual exclusion among JUMP/CALL/RET is the caller's responsibility.
- CALL with the stack full: IP still goes to jump_addr, the push is discarded, err[1]<=1.
- RET with the stack empty: IP = ip_eff+1, err[2]<=1.
- RELOAD cycle N: at edge N+1, IP_curr and ip_eff <= IP_mem[thread_num_ahead]; instr_valid<=0 and fetch enabled.
- Fetch read is issued when fetch is enabled and INSTR_WAIT=0. That gives instruction=mem[IP_curr] at edge N+2, instr_valid=1 from N+2, IP_curr increments per read.
- INSTR_WAIT=1: no read, IP_curr held, instruction and instr_valid held.
- INVALIDATE: at the next edge instr_valid<=0 and fetch is disabled until RELOAD.
- INVALIDATE together with RELOAD: RELOAD wins, err[0]<=1.
- EXECUTED without NEXT_THREAD: ip_eff+1. Combined with RELOAD: RELOAD wins.
- All IP arithmetic wraps modulo 2^IADDR_LEN. Stack pointer counts 0..STACK_DEPTH.
- Program store: one write port, one read port, read-first. Simultaneous write and read of the same address returns old data.
- Entry table: write takes effect at the next edge. An INIT in the same cycle uses the old value.
- err bits are sticky until reset.

Decomposition:
- Shared header sha256.vh gains IADDR_LEN, INSTR_LEN, ENTRY_PT_MSB, STACK_DEPTH defines, plus err bit indices ERR_INV_RELOAD=0, ERR_STK_OVF=1, ERR_STK_UNF=2, ERR_CF_NO_NT=3.
- One natural sub-module, thread_ret_stack: per-thread LUTRAM stack plus pointer array, with push/pop/full/empty.

Test Plan:
1. Write entry[1]=150. INIT thread 0 with entry_pt_curr=1. RELOAD with thread_num_ahead=0 -> ip_eff=150; instruction=mem[150] valid 2 cycles after RELOAD, then mem[151], mem[152].
2. Thread 2 at ip_eff=40: CALL+NEXT_THREAD with jump_addr=300, then RELOAD; later RET+NEXT_THREAD -> IP[2]=300 after the call and 41 after the return; err=0.
3. STACK_DEPTH=2: three nested CALLs -> third target taken, err[1]=1. Then three RETs -> the third yields ip_eff+1 and err[2]=1.
4. INSTR_WAIT held 3 cycles mid-stream -> instruction, instr_valid and IP_curr frozen. Next read resumes at the stalled address.
5. INVALIDATE and RELOAD in the same cycle -> reload proceeds and err[0]=1. JUMP without NEXT_THREAD -> IP[thread_num] unchanged and err[3]=1.
6. prog_wr to address 151 while reading 151 -> old word returned; the next read returns the new word. RST_N low mid-fetch -> all outputs 0 immediately.
